layer3_result_mem_ctrl: RTL
===========================

Name: layer3_result_mem_ctrl

Overview:
Sequencer for the layer-3 result memory, a WIDTH x WIDTH array of DATA_W-bit words with a synchronous write port and a combinational, read-signal-gated read port.
- FILL: accepts the layer-3 output stream in raster order over a valid/ready handshake and generates the save-side addresses and enables.
- DRAIN: once the frame is complete, reads the array back in raster order and presents it to layer 4 over a registered valid/ready output.

Parameters:
WIDTH, 8, feature-map side length (rows = cols = WIDTH); must be 2..255.
DATA_W, 128, word width; equals the layer-3 output length.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a frame when in IDLE.
clear  input  1  synchronous abort to IDLE; has priority over every other input.
in_valid  input  1  layer-3 word valid.
in_ready  output  1  controller accepts a layer-3 word.
in_data  input  DATA_W  layer-3 word.
save_enable  output  1  memory write enable.
save_row_addr  output  16  write row.
save_col_addr  output  16  write column.
store_data_out  output  DATA_W  memory write data.
read_signal  output  1  memory read enable.
read_row_addr  output  16  read row.
read_col_addr  output  16  read column.
mem_rdata  input  DATA_W  memory read data, combinational from the read address.
out_valid  output  1  layer-4 word valid.
out_ready  input  1  layer-4 accepts a word.
out_data  output  DATA_W  layer-4 word, registered.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse when the final word is accepted by layer 4.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters 0; out_valid=0; out_data=0; done=0.
  - All combinational outputs evaluate to 0 in IDLE.
- FSM states: IDLE, FILL, DRAIN.
  - IDLE -> FILL on start.
  - FILL -> DRAIN on the write beat at (WIDTH-1, WIDTH-1).
  - DRAIN -> IDLE on the cycle the last word is accepted (out_valid & out_ready & last_q); done=1 in that same cycle.
  - start while not IDLE is ignored.
  - clear from any state: next state IDLE, counters 0, out_valid 0, no done pulse. A partially written frame is left in memory.
- FILL:
  - in_ready=1.
  - save_enable = in_valid & in_ready (combinational, zero latency).
  - save_row_addr / save_col_addr = wr_row / wr_col, zero-extended to 16 bits.
  - store_data_out = in_data.
  - On each beat: wr_col++. At wr_col=WIDTH-1, wr_col wraps to 0 and wr_row++.
  - in_valid=0 inserts stalls with no side effects.
- DRAIN:
  - in_ready=0 and save_enable=0. in_valid is ignored.
  - fetch = (state==DRAIN) & !rd_exhausted & (!out_valid | out_ready).
  - When fetch=1 the same cycle carries: read_signal=1, read_row_addr=rd_row, read_col_addr=rd_col. On the next edge: out_data<=mem_rdata, out_valid<=1, last_q<=(rd_row==WIDTH-1 & rd_col==WIDTH-1), then rd counters advance with the same wrap rule as the write side.
  - Fetching (WIDTH-1, WIDTH-1) sets rd_exhausted.
  - If out_valid & out_ready & !fetch, out_valid<=0.
  - Throughput is 1 word/cycle with out_ready held high. The first out_valid appears 1 cycle after entering DRAIN.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable and read_signal=0.
- Outside DRAIN-fetch cycles, read_signal=0 and the read addresses are 0.
- Counters are 8-bit internally. Address outputs have bits [15:8] always 0.

Decomposition:
- Shared package (layer3_ctrl_pkg):
  - state enum typedef (IDLE, FILL, DRAIN);
  - ADDR_W=16 constant;
  - default WIDTH and DATA_W constants, matching the layer-4 width and layer-3 output length definitions.
- One natural sub-module, raster_addr_cnt: row/col counter with an increment enable, synchronous clear, and a wrap/last flag. It is instantiated twice, once for the write side and once for the read side.

Test Plan:
- Reset then idle, WIDTH=4: hold rst=0 mid-frame -> busy=0, out_valid=0, save_enable=0, read_signal=0 immediately; no done pulse.
- Full frame, WIDTH=4, in_valid always 1, data=0x10+n: start -> 16 writes at (0,0)..(3,3), second beat at (0,1), fifth beat at (1,0); then out_data sequence 0x10..0x1F with out_valid on consecutive cycles; done pulses exactly once, with the 16th acceptance.
- Input stalls: in_valid toggled 1,0,0,1,... -> save_enable only on valid cycles; addresses advance only on beats; write order unchanged.
- Output backpressure: out_ready low for 5 cycles at word 6 -> out_data=word 6 held stable, read_signal=0 during the stall, no skipped or duplicated words, total 16 words.
- Abort: clear at write beat 7 -> next cycle IDLE, busy=0. A following start restarts writing at (0,0).
- Ignored start: start pulsed during FILL and during DRAIN -> counters and state unaffected; exactly one done per frame.

Source files
------------

// File: rtl/layer3_ctrl_pkg.sv
// Shared types and constants for the layer-3 result memory sequencer.
package layer3_ctrl_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned CNT_W      = 8;
  // Layer-4 feature-map side and layer-3 output vector length.
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/layer3_result_mem_ctrl_if.sv
// Stream, memory-port and layer-4 signals of the layer-3 result memory sequencer.
interface layer3_result_mem_ctrl_if #(
  parameter int unsigned DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              save_enable;
  logic [15:0]       save_row_addr;
  logic [15:0]       save_col_addr;
  logic [DATA_W-1:0] store_data_out;
  logic              read_signal;
  logic [15:0]       read_row_addr;
  logic [15:0]       read_col_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  in_valid, in_data, mem_rdata, out_ready,
    output in_ready, save_enable, save_row_addr, save_col_addr, store_data_out,
           read_signal, read_row_addr, read_col_addr, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, mem_rdata, out_ready,
    input  in_ready, save_enable, save_row_addr, save_col_addr, store_data_out,
           read_signal, read_row_addr, read_col_addr, out_valid, out_data
  );
endinterface

// File: rtl/raster_addr_cnt.sv
// Raster-order row/column counter with increment enable, synchronous clear and last flag.
module raster_addr_cnt
  import layer3_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last
);

  localparam logic [CNT_W-1:0] MaxIdx = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             col_wrap;

  always_comb begin
    col_wrap = (col_q == MaxIdx);
    last     = col_wrap && (row_q == MaxIdx);
    row_d    = row_q;
    col_d    = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_wrap) begin
        col_d = '0;
        // Wrapping the row too leaves the counter at (0,0) after a full frame.
        row_d = (row_q == MaxIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/layer3_result_mem_ctrl.sv
// Fills the layer-3 result memory from the layer-3 stream, then drains it to layer 4.
module layer3_result_mem_ctrl
  import layer3_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clear,
  output logic                     busy,
  output logic                     done,
  layer3_result_mem_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              last_q, last_d;
  logic              rd_exh_q, rd_exh_d;

  logic              fill, fetch, save_en, accept;
  logic [CNT_W-1:0]  wr_row, wr_col, rd_row, rd_col;
  logic              wr_last, rd_last;

  raster_addr_cnt #(
    .WIDTH(WIDTH)
  ) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (save_en && !clear),
    .row  (wr_row),
    .col  (wr_col),
    .last (wr_last)
  );

  raster_addr_cnt #(
    .WIDTH(WIDTH)
  ) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (fetch && !clear),
    .row  (rd_row),
    .col  (rd_col),
    .last (rd_last)
  );

  always_comb begin
    fill    = (state_q == StFill);
    save_en = fill && bus.in_valid;
    fetch   = (state_q == StDrain) && !rd_exh_q && (!out_valid_q || bus.out_ready);
    accept  = out_valid_q && bus.out_ready;

    bus.in_ready       = fill;
    bus.save_enable    = save_en;
    bus.save_row_addr  = fill ? ADDR_W'(wr_row) : '0;
    bus.save_col_addr  = fill ? ADDR_W'(wr_col) : '0;
    bus.store_data_out = fill ? bus.in_data : '0;
    bus.read_signal    = fetch;
    bus.read_row_addr  = fetch ? ADDR_W'(rd_row) : '0;
    bus.read_col_addr  = fetch ? ADDR_W'(rd_col) : '0;
    bus.out_valid      = out_valid_q;
    bus.out_data       = out_data_q;

    busy = (state_q != StIdle);
    done = (state_q == StDrain) && accept && last_q && !clear;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFill;
      StFill:  if (save_en && wr_last) state_d = StDrain;
      StDrain: if (accept && last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    rd_exh_d    = rd_exh_q;
    if (clear) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
      rd_exh_d    = 1'b0;
    end else begin
      if (fetch) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.mem_rdata;
        last_d      = rd_last;
      end else if (accept) begin
        out_valid_d = 1'b0;
      end
      // Exhaustion only matters inside DRAIN; re-arm it for the next frame.
      if (state_q != StDrain) begin
        rd_exh_d = 1'b0;
      end else if (fetch && rd_last) begin
        rd_exh_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
      rd_exh_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      rd_exh_q    <= rd_exh_d;
    end
  end

endmodule
